// File: rtl/packet_injector_9_nodes.sv
// packet_injector_9_nodes: operator-driven packet source for the 9 router inputs of the ring, with FIFO, timed pulse FSM and 7-seg readout. Optional AUTO_INJECT_EN adds periodic injection while sw_on is held. Ports: clk, rst_n, sw_on, sw_sel_data, sw_sel_router, key_inc, key_dec in; out_router1..9 {valid,s1,s2}, hex_data, hex_router, fifo_full, overflow, busy out.
module packet_injector_9_nodes #(
  parameter int K = 4,
  parameter int N2 = 9,
  parameter int NODES = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES = 1,
  parameter int AUTO_PERIOD = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sw_on,
  input  logic          sw_sel_data,
  input  logic          sw_sel_router,
  input  logic          key_inc,
  input  logic          key_dec,
  output logic [N2-1:0] out_router1,
  output logic [N2-1:0] out_router2,
  output logic [N2-1:0] out_router3,
  output logic [N2-1:0] out_router4,
  output logic [N2-1:0] out_router5,
  output logic [N2-1:0] out_router6,
  output logic [N2-1:0] out_router7,
  output logic [N2-1:0] out_router8,
  output logic [N2-1:0] out_router9,
  output logic [6:0]    hex_data,
  output logic [6:0]    hex_router,
  output logic          fifo_full,
  output logic          overflow,
  output logic          busy
);
  localparam int IW = $clog2(NODES);
  localparam int EW = IW + 2 * K;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  // bit order: 4 on, 3 sel_data, 2 sel_router, 1 inc, 0 dec; keys idle high
  logic [4:0] sy_a, sy;
  logic [1:0] lvl, press;
  logic [DW-1:0] dcnt [2];
  logic inc, dec, on_d, rise, push, pop, wr, empty;
  logic [IW-1:0] idx;
  logic [K-1:0] f1, f2;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] cur;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [TW-1:0] tcnt;
  state_t state, nxt;
  logic [N2-1:0] bus [NODES];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sy_a <= 5'b00011;
      sy <= 5'b00011;
    end else begin
      sy_a <= {sw_on, sw_sel_data, sw_sel_router, key_inc, key_dec};
      sy <= sy_a;
    end
  end
  // a key level is accepted once it has differed from the accepted level for DEBOUNCE_CYCLES samples in a row
  always_comb begin
    for (int i = 0; i < 2; i++)
      press[i] = sy[i] != lvl[i] && dcnt[i] == DW'(DEBOUNCE_CYCLES - 1) && !sy[i];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl <= 2'b11;
      dcnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sy[i] == lvl[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= sy[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end
  assign inc = press[1] & ~press[0];
  assign dec = press[0] & ~press[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      f1 <= '0;
      f2 <= '0;
    end else if (inc | dec) begin
      if (sy[2]) idx <= inc ? (idx == IW'(NODES - 1) ? '0 : idx + 1'b1) : (idx == '0 ? IW'(NODES - 1) : idx - 1'b1);
      else if (sy[3]) f2 <= inc ? f2 + 1'b1 : f2 - 1'b1;
      else f1 <= inc ? f1 + 1'b1 : f1 - 1'b1;
    end
  end
  assign rise = sy[4] & ~on_d;
  always_ff @(posedge clk) on_d <= rst_n & sy[4];
`ifdef AUTO_INJECT_EN
  localparam int AW = $clog2(AUTO_PERIOD);
  // acnt tracks cycles since the rising edge modulo AUTO_PERIOD; zero while held means a period elapsed
  logic [AW-1:0] acnt;
  always_ff @(posedge clk) begin
    if (!rst_n || !sy[4]) acnt <= '0;
    else if (rise) acnt <= AW'(1);
    else acnt <= acnt == AW'(AUTO_PERIOD - 1) ? '0 : acnt + 1'b1;
  end
  assign push = rise | (sy[4] & on_d & acnt == '0);
`else
  assign push = rise;
`endif
  assign empty = cnt == '0;
  assign fifo_full = cnt == (PW + 1)'(FIFO_DEPTH);
  assign pop = state == IDLE && !empty;
  assign wr = push && (!fifo_full || pop);
  always_ff @(posedge clk) if (wr) mem[wp] <= {idx, f1, f2};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wp <= wp + PW'(wr);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW + 1)'(wr) - (PW + 1)'(pop);
      if (push && !wr) overflow <= 1'b1;
    end
  end
  always_comb
    nxt = state == IDLE ? (empty ? IDLE : DRIVE)
        : state == DRIVE ? (tcnt == TW'(HOLD_CYCLES - 1) ? (GAP_CYCLES == 0 ? IDLE : GAP) : DRIVE)
        : (tcnt == TW'(GAP_CYCLES - 1) ? IDLE : GAP);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tcnt <= '0;
      cur <= '0;
    end else begin
      state <= nxt;
      tcnt <= nxt != state ? '0 : tcnt + 1'b1;
      if (pop) cur <= mem[rp];
    end
  end
  always_comb begin
    for (int r = 0; r < NODES; r++)
      bus[r] = state == DRIVE && cur[EW-1 -: IW] == IW'(r) ? {1'b1, cur[2*K-1:0]} : '0;
  end
  assign out_router1 = bus[0];
  assign out_router2 = bus[1];
  assign out_router3 = bus[2];
  assign out_router4 = bus[3];
  assign out_router5 = bus[4];
  assign out_router6 = bus[5];
  assign out_router7 = bus[6];
  assign out_router8 = bus[7];
  assign out_router9 = bus[8];
  assign hex_data = SEG[sy[3] ? f2 : f1];
  assign hex_router = SEG[4'(idx)];
  assign busy = state != IDLE || !empty;
endmodule

// File: tb/tb_packet_injector_9_nodes.sv
// tb_packet_injector_9_nodes: directed checks of editing, injection timing, FIFO overflow, debounce and reset.
module tb_packet_injector_9_nodes;
  logic clk = 0, rst_n = 0, sw_on = 0, sw_sel_data = 0, sw_sel_router = 0, key_inc = 1, key_dec = 1;
  logic [8:0] a [9];
  logic [8:0] b [9];
  logic [6:0] hd, hr, hd2, hr2;
  logic ff, ov, bz, ff2, ov2, bz2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  packet_injector_9_nodes dut (
    .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .sw_sel_data(sw_sel_data), .sw_sel_router(sw_sel_router),
    .key_inc(key_inc), .key_dec(key_dec),
    .out_router1(a[0]), .out_router2(a[1]), .out_router3(a[2]), .out_router4(a[3]), .out_router5(a[4]),
    .out_router6(a[5]), .out_router7(a[6]), .out_router8(a[7]), .out_router9(a[8]),
    .hex_data(hd), .hex_router(hr), .fifo_full(ff), .overflow(ov), .busy(bz));
  // long hold keeps this copy busy so its queue can be filled by the operator
  packet_injector_9_nodes #(.HOLD_CYCLES(300)) dut2 (
    .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .sw_sel_data(sw_sel_data), .sw_sel_router(sw_sel_router),
    .key_inc(key_inc), .key_dec(key_dec),
    .out_router1(b[0]), .out_router2(b[1]), .out_router3(b[2]), .out_router4(b[3]), .out_router5(b[4]),
    .out_router6(b[5]), .out_router7(b[6]), .out_router8(b[7]), .out_router9(b[8]),
    .hex_data(hd2), .hex_router(hr2), .fifo_full(ff2), .overflow(ov2), .busy(bz2));
  function automatic int nz(input bit d);
    int n = 0;
    for (int r = 0; r < 9; r++) n += ((d ? b[r] : a[r]) != 0) ? 1 : 0;
    return n;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    tick(3);
    rst_n = 1;
  endtask
  task automatic press(input bit up);
    @(negedge clk);
    if (up) key_inc = 0; else key_dec = 0;
    tick(24);
    key_inc = 1;
    key_dec = 1;
    tick(24);
  endtask
  task automatic edge_on();
    @(negedge clk);
    sw_on = 1;
    @(negedge clk);
    sw_on = 0;
  endtask
  task automatic wait_pkt(input bit d, input int r, input logic [8:0] v, input int hold);
    int i;
    logic [8:0] obs;
    for (i = 0; i < 40 && nz(d) == 0; i++) @(negedge clk);
    checks++;
    if (i == 40) begin
      errors++;
      $display("FAIL pkt_timeout dut%0d router%0d: no packet within 40 cycles", d + 1, r + 1);
      return;
    end
    for (int c = 0; c < hold; c++) begin
      obs = d ? b[r] : a[r];
      checks++;
      if (obs !== v || nz(d) != 1) begin
        errors++;
        $display("FAIL pkt_hold dut%0d router%0d cycle %0d: got %h (%0d buses active), expected %h alone", d + 1, r + 1, c, obs, nz(d), v);
      end
      @(negedge clk);
    end
    checks++;
    if (nz(d) != 0) begin
      errors++;
      $display("FAIL pkt_gap dut%0d: %0d buses active after hold, expected 0", d + 1, nz(d));
    end
  endtask
  task automatic test_reset();
    int i, m;
    do_reset();
    tick(1);
    checks++;
    if (nz(0) != 0 || bz !== 0 || ff !== 0 || ov !== 0 || hd !== 7'h40 || hr !== 7'h40) begin
      errors++;
      $display("FAIL reset_state: buses=%0d busy=%b full=%b ovf=%b hd=%h hr=%h, expected 0 0 0 0 40 40", nz(0), bz, ff, ov, hd, hr);
    end
    edge_on();
    for (i = 0; i < 40 && nz(0) == 0; i++) @(negedge clk);
    checks++;
    if (i == 40) begin
      errors++;
      $display("FAIL reset_setup: no packet to interrupt");
    end
    rst_n = 0;
    tick(3);
    rst_n = 1;
    m = 0;
    for (int c = 0; c < 20; c++) begin
      if (nz(0) > m) m = nz(0);
      @(negedge clk);
    end
    checks++;
    if (m != 0 || bz !== 0 || ov !== 0 || hd !== 7'h40 || hr !== 7'h40) begin
      errors++;
      $display("FAIL reset_mid_drive: max buses=%0d busy=%b ovf=%b hd=%h hr=%h, expected 0 0 0 40 40", m, bz, ov, hd, hr);
    end
  endtask
  task automatic test_router_edit();
    sw_sel_router = 1;
    tick(4);
    press(0);
    checks++;
    if (hr !== 7'h00) begin
      errors++;
      $display("FAIL idx_wrap_down: hex_router=%h, expected 00 (8)", hr);
    end
    press(0);
    press(0);
    checks++;
    if (hr !== 7'h02) begin
      errors++;
      $display("FAIL idx_dec: hex_router=%h, expected 02 (6)", hr);
    end
    edge_on();
    wait_pkt(0, 6, 9'h100, 2);
  endtask
  task automatic test_data_edit();
    sw_sel_router = 0;
    sw_sel_data = 0;
    tick(4);
    repeat (3) press(1);
    checks++;
    if (hd !== 7'h30) begin
      errors++;
      $display("FAIL s1_inc: hex_data=%h, expected 30 (3)", hd);
    end
    sw_sel_data = 1;
    tick(4);
    checks++;
    if (hd !== 7'h40) begin
      errors++;
      $display("FAIL s2_select: hex_data=%h, expected 40 (0)", hd);
    end
    press(0);
    checks++;
    if (hd !== 7'h0E) begin
      errors++;
      $display("FAIL s2_wrap_down: hex_data=%h, expected 0E (F)", hd);
    end
    sw_sel_router = 1;
    tick(4);
    repeat (3) press(1);
    checks++;
    if (hr !== 7'h40) begin
      errors++;
      $display("FAIL idx_wrap_up: hex_router=%h, expected 40 (0)", hr);
    end
    edge_on();
    wait_pkt(0, 0, 9'h13F, 2);
  endtask
  task automatic test_overflow();
    int i;
    do_reset();
    sw_sel_router = 1;
    sw_sel_data = 0;
    tick(4);
    edge_on();
    repeat (4) press(1);
    checks++;
    if (hr !== 7'h19) begin
      errors++;
      $display("FAIL ovf_idx: hex_router=%h, expected 19 (4)", hr);
    end
    repeat (6) edge_on();
    tick(4);
    checks++;
    if (ff2 !== 1 || ov2 !== 1 || ov !== 0) begin
      errors++;
      $display("FAIL fifo_overflow: full=%b ovf=%b fast-dut ovf=%b, expected 1 1 0", ff2, ov2, ov);
    end
    for (i = 0; i < 400 && b[0] != 0; i++) @(negedge clk);
    checks++;
    if (i == 400) begin
      errors++;
      $display("FAIL ovf_first_pkt: router1 still driven after 400 cycles");
    end
    repeat (4) wait_pkt(1, 4, 9'h100, 300);
    tick(50);
    checks++;
    if (nz(1) != 0 || bz2 !== 0 || ff2 !== 0 || ov2 !== 1) begin
      errors++;
      $display("FAIL ovf_drain: buses=%0d busy=%b full=%b ovf=%b, expected 0 0 0 1", nz(1), bz2, ff2, ov2);
    end
  endtask
  task automatic test_bounce();
    sw_sel_router = 0;
    sw_sel_data = 0;
    tick(4);
    repeat (3) begin
      key_inc = 0;
      tick(5);
      key_inc = 1;
      tick(10);
    end
    tick(30);
    checks++;
    if (hd !== 7'h40) begin
      errors++;
      $display("FAIL bounce_glitch: hex_data=%h, expected 40", hd);
    end
    key_inc = 0;
    key_dec = 0;
    tick(24);
    key_inc = 1;
    key_dec = 1;
    tick(24);
    checks++;
    if (hd !== 7'h40) begin
      errors++;
      $display("FAIL both_keys_data: hex_data=%h, expected 40", hd);
    end
    sw_sel_router = 1;
    tick(4);
    key_inc = 0;
    key_dec = 0;
    tick(24);
    key_inc = 1;
    key_dec = 1;
    tick(24);
    checks++;
    if (hr !== 7'h19) begin
      errors++;
      $display("FAIL both_keys_router: hex_router=%h, expected 19", hr);
    end
    edge_on();
    wait_pkt(0, 4, 9'h100, 2);
  endtask
  task automatic test_hold();
    int n = 0, exp_n;
    logic prev = 0;
`ifdef AUTO_INJECT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    @(negedge clk);
    sw_on = 1;
    for (int c = 0; c < 240; c++) begin
      if (c == 200) sw_on = 0;
      if (a[4][8] && !prev) n++;
      prev = a[4][8];
      @(negedge clk);
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL held_sw_on: %0d packets on router5, expected %0d", n, exp_n);
    end
  endtask
  initial begin
    test_reset();
    test_router_edit();
    test_data_edit();
    test_overflow();
    test_bounce();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
